vram_port_arbiter: RTL
======================

// Module: vram_port_arbiter
// PURPOSE
//  Shares the single-port paint VRAM between three requesters:
//  R0 = display scan reader, R1 = paint/palette-change engine, R2 = cursor overlay.
//  Sits between the paint control FSM datapaths and the VRAM macro.
//  Arbitration: fixed priority for R0; round-robin between R1 and R2.
//  Bursts are bounded so that no requester starves another.
// PARAMETERS
//  ADDR_W     12  VRAM word address width (64x64 canvas)
//  DATA_W      8  VRAM word width (palette index + flags)
//  MAX_BURST   8  max consecutive beats for one owner while another requests; >=1
// PORTS
//  clk        in   1          system clock; all logic on posedge
//  rst        in   1          synchronous reset, active-low (0 = reset)
//  req        in   3          per-requester request; bit i = Ri
//  we         in   3          per-requester write enable, sampled with addr
//  addr       in   3*ADDR_W   Ri address at [i*ADDR_W +: ADDR_W]
//  wdata      in   3*DATA_W   Ri write data at [i*DATA_W +: DATA_W]
//  gnt        out  3          one-hot beat accept; Ri's access issues this cycle
//  rvalid     out  3          one-hot read-data valid, 1 cycle after a read gnt
//  rdata      out  DATA_W     read data, shared; qualified by rvalid
//  mem_addr   out  ADDR_W     VRAM address
//  mem_we     out  1          VRAM write strobe
//  mem_wdata  out  DATA_W     VRAM write data
//  mem_rdata  in   DATA_W     VRAM read data, registered 1 cycle after address
// BEHAVIOUR
//  Reset (rst=0 at posedge):
//   - gnt=0, rvalid=0, mem_we=0; mem_addr/mem_wdata/rdata=0
//   - state=IDLE, burst_cnt=0, rr_ptr=R1
//   - an in-flight read's rvalid is suppressed
//  Handshake:
//   - Ri holds req/we/addr/wdata stable until it sees gnt[i]=1.
//   - Each gnt cycle is one beat.
//   - Keeping req high after gnt requests another beat; inputs may change after a gnt.
//  Issue: gnt, sel, mem_addr, mem_we and mem_wdata are registered.
//   - A winner chosen at edge T drives gnt[sel]=1 and its access to VRAM during cycle T..T+1.
//   - Request-to-gnt latency: 1 cycle minimum.
//   - Back-to-back beats at 1/cycle for the owner.
//   - The requester must drop req in the cycle it sees gnt if it wants no further beat;
//     the arbiter treats req sampled in the gnt cycle as the next request.
//  Read return: a read beat granted in cycle T gives rvalid[sel]=1 and rdata=mem_rdata
//   in cycle T+1. Writes produce no rvalid.
//  FSM:
//   - IDLE: no beat issued. If any req, pick winner: R0 if req[0]; else rr_ptr order among R1/R2.
//     Issue a beat, burst_cnt=1 -> OWN.
//   - OWN, owner still requesting and (burst_cnt<MAX_BURST or no other req):
//     issue the next beat, burst_cnt++ (saturates).
//   - OWN, owner drops req or burst limit reached with a competitor:
//     re-arbitrate this same edge, excluding the owner if a competitor exists.
//     No bubble; burst_cnt=1 for the new owner.
//   - OWN, no req at all -> IDLE, gnt=0.
//  Pre-emption: R0 requesting while R1/R2 owns -> R0 wins at the next edge.
//   This happens regardless of burst_cnt; the owner's beat in flight completes.
//  Round-robin: rr_ptr points to the other of R1/R2 after any R1/R2 grant ends its burst.
//   Simultaneous R1+R2 (no R0) -> rr_ptr decides.
//  Boundaries:
//   - MAX_BURST=1 -> strict alternation among competing requesters.
//   - A lone requester is never throttled.
//   - req without any gnt never blocks others.
//   - req deasserted before gnt: request is withdrawn, no beat issued.
//  Invariants: gnt and rvalid are one-hot or zero. mem_we=1 only in a gnt cycle with we[sel]=1.
// STRUCTURE
//  Shared package vram_pkg:
//   - requester index constants REQ_DISP=0, REQ_PAINT=1, REQ_CURS=2
//   - NUM_REQ=3
//   - ADDR_W/DATA_W defaults
//   - arbiter state encodings IDLE/OWN
//  Sub-module rr_pick2: combinational R1/R2 round-robin chooser (req pair + rr_ptr -> winner).
//  Top holds the FSM, burst counter, read-return pipeline register and VRAM output mux.
// TESTING
//  1. Reset: drive rst=0 with req=3'b111 for 2 cycles -> gnt=0, rvalid=0, mem_we=0.
//     Release rst -> first gnt=3'b001.
//  2. Lone R1 writes addr 0x010..0x01F (16 beats) -> gnt[1] high 16 consecutive cycles,
//     mem_we=1 each, no throttling.
//  3. R1 and R2 request continuously, MAX_BURST=8 -> 8 R1 beats, 8 R2 beats, alternating,
//     with no idle cycle.
//  4. R2 in burst, R0 read of 0x0A5 raised -> gnt[0] next cycle.
//     Next cycle: rvalid=3'b001 with rdata=VRAM[0x0A5].
//     R2 then resumes.
//  5. R1 read granted in cycle T, rst=0 in cycle T+1 -> rvalid stays 0.
//     After release, rr_ptr=R1.
//  6. R1+R2 raise req on the same edge from IDLE -> R1 wins first (rr_ptr=R1).
//     Repeat after R2's burst -> R1 wins again.

Source files
------------

// File: rtl/vram_pkg.sv
// vram_pkg: shared constants, state encodings and helpers for the VRAM port arbiter
package vram_pkg;
  localparam int NUM_REQ = 3;
  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 8;
  localparam logic [1:0] REQ_DISP = 2'd0;
  localparam logic [1:0] REQ_PAINT = 2'd1;
  localparam logic [1:0] REQ_CURS = 2'd2;
  typedef enum logic {IDLE, OWN} arb_state_t;
  function automatic logic [NUM_REQ-1:0] req_onehot(input logic [1:0] idx);
    return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: round-robin chooser between the paint engine and the cursor overlay
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       pick
);
  // req[0]=R1, req[1]=R2; ptr=1 gives R2 priority; pick=1 selects R2
  always_comb pick = ptr ? req[1] : (req[1] && !req[0]);
endmodule

// File: rtl/vram_port_arbiter.sv
// vram_port_arbiter: shares the single-port paint VRAM between display, paint and cursor requesters
module vram_port_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int MAX_BURST = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_we,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  arb_state_t state;
  logic [1:0] sel, win;
  logic [CNT_W-1:0] burst_cnt;
  logic rr_ptr;
  logic [NUM_REQ-1:0] own_mask, others, cand;
  logic own_req, keep, rr_pick;

  rr_pick2 u_rr (.req(cand[2:1]), .ptr(rr_ptr), .pick(rr_pick));

  // next winner: keep the owner within its burst budget unless R0 pre-empts, else re-arbitrate excluding the owner
  always_comb begin
    own_mask = (state == OWN) ? req_onehot(sel) : '0;
    others = req & ~own_mask;
    own_req = |(req & own_mask);
    keep = own_req && (burst_cnt < CNT_W'(MAX_BURST) || others == '0) && !(sel != REQ_DISP && req[REQ_DISP]);
    cand = (others != '0) ? others : req;
    win = keep ? sel : cand[REQ_DISP] ? REQ_DISP : rr_pick ? REQ_CURS : REQ_PAINT;
  end

  // arbiter FSM with registered grant, VRAM access and read-return flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      sel <= REQ_DISP;
      burst_cnt <= '0;
      rr_ptr <= 1'b0;
      gnt <= '0;
      rvalid <= '0;
      mem_addr <= '0;
      mem_we <= 1'b0;
      mem_wdata <= '0;
    end else begin
      rvalid <= mem_we ? '0 : gnt;
      if (state == OWN && sel != REQ_DISP && !keep) rr_ptr <= (sel == REQ_PAINT);
      if (req == '0) begin
        state <= IDLE;
        burst_cnt <= '0;
        gnt <= '0;
        mem_we <= 1'b0;
      end else begin
        state <= OWN;
        sel <= win;
        burst_cnt <= keep ? burst_cnt + CNT_W'(burst_cnt != CNT_W'(MAX_BURST)) : CNT_W'(1);
        gnt <= req_onehot(win);
        mem_addr <= addr[win*ADDR_W +: ADDR_W];
        mem_we <= we[win];
        mem_wdata <= wdata[win*DATA_W +: DATA_W];
      end
    end
  end

  // read data is only meaningful alongside rvalid, so it is held at zero otherwise
  always_comb rdata = (rvalid != '0) ? mem_rdata : '0;
endmodule
